// File: rtl/spi_poll_scheduler_pkg.sv
// Shared definitions for the SPI polling master: state encodings,
// polarity constants and small elaboration-time helpers.
package spi_poll_scheduler_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_LOW   = 3'd2,
    ST_HIGH  = 3'd3,
    ST_HOLD  = 3'd4,
    ST_GAP   = 3'd5
  } spi_state_e;

  localparam int SS_ACTIVE_HIGH = 1;
  localparam int SCLK_IDLE_HIGH = 1;

  // Width of every phase counter (setup, half-period, hold, gap).
  localparam int PHASE_CNT_W = 16;

  // Index width for n channels; a single channel still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_round_robin_arbiter.sv
// Combinational round-robin pick: first set request at or after pointer,
// wrapping. The pointer register itself lives in the scheduler.
module spi_round_robin_arbiter
  import spi_poll_scheduler_pkg::*;
#(
  parameter  int channels = 4,
  localparam int IDX_W    = idx_width(channels)
) (
  input  logic [channels-1:0] request,
  input  logic [IDX_W-1:0]    pointer,
  input  logic                enable,
  output logic [channels-1:0] grant,
  output logic [IDX_W-1:0]    index
);

  logic [IDX_W:0] cand;
  logic           found;

  // Scan channels starting at the pointer; the first hit wins.
  always_comb begin
    grant = '0;
    index = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = 0; i < channels; i++) begin
      cand = {1'b0, pointer} + (IDX_W+1)'(i);
      if (cand >= (IDX_W+1)'(channels)) cand = cand - (IDX_W+1)'(channels);
      if (enable && !found && request[cand[IDX_W-1:0]]) begin
        found                   = 1'b1;
        grant[cand[IDX_W-1:0]]  = 1'b1;
        index                   = cand[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/spi_poll_scheduler.sv
// SPI master (CPOL=1/CPHA=1 internally, MSB first) shared among several
// slaves; grants one requester at a time round-robin and returns the word
// with its channel index and a one-cycle valid pulse.
module spi_poll_scheduler
  import spi_poll_scheduler_pkg::*;
#(
  parameter  int channels      = 4,
  parameter  int bitcount      = 16,
  parameter  int clock_divider = 4,
  parameter  int setup_cycles  = 2,
  parameter  int hold_cycles   = 2,
  parameter  int gap_cycles    = 2,
  parameter  int ss_polarity   = 0,
  parameter  int sclk_polarity = 1,
  localparam int IDX_W         = idx_width(channels)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [channels-1:0] request,
  output logic [channels-1:0] grant,
  output logic [channels-1:0] ss,
  output logic                sclk,
  input  logic                sdi,
  output logic [bitcount-1:0] data,
  output logic [IDX_W-1:0]    channel,
  output logic                valid,
  output logic                busy
);

  localparam int BIT_W = $clog2(bitcount) + 1;
  localparam logic [PHASE_CNT_W-1:0] SETUP_LAST = PHASE_CNT_W'(setup_cycles - 1);
  localparam logic [PHASE_CNT_W-1:0] DIV_LAST   = PHASE_CNT_W'(clock_divider - 1);
  localparam logic [PHASE_CNT_W-1:0] HOLD_LAST  = PHASE_CNT_W'(hold_cycles - 1);
  localparam logic [PHASE_CNT_W-1:0] GAP_LAST   = PHASE_CNT_W'(gap_cycles - 1);
  localparam logic [BIT_W-1:0]       BIT_LAST   = BIT_W'(bitcount);
  localparam logic [IDX_W-1:0]       IDX_MAX    = IDX_W'(channels - 1);

  spi_state_e               state_q, state_d;
  logic [PHASE_CNT_W-1:0]   cnt_q, cnt_d;
  logic [BIT_W-1:0]         bit_q, bit_d;
  logic [bitcount-1:0]      shift_q, shift_d;
  logic [channels-1:0]      grant_q, grant_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [IDX_W-1:0]         ptr_q, ptr_d;
  logic [bitcount-1:0]      data_q, data_d;
  logic [IDX_W-1:0]         chan_q, chan_d;
  logic                     valid_q, valid_d;
  logic                     sclk_low_q, sclk_low_d;

  logic [channels-1:0]      arb_grant;
  logic [IDX_W-1:0]         arb_index;

  spi_round_robin_arbiter #(.channels(channels)) u_arb (
    .request (request),
    .pointer (ptr_q),
    .enable  (state_q == ST_IDLE),
    .grant   (arb_grant),
    .index   (arb_index)
  );

  // State and datapath registers; reset aborts any transfer immediately.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      grant_q    <= '0;
      idx_q      <= '0;
      ptr_q      <= '0;
      data_q     <= '0;
      chan_q     <= '0;
      valid_q    <= 1'b0;
      sclk_low_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      grant_q    <= grant_d;
      idx_q      <= idx_d;
      ptr_q      <= ptr_d;
      data_q     <= data_d;
      chan_q     <= chan_d;
      valid_q    <= valid_d;
      sclk_low_q <= sclk_low_d;
    end
  end

  // Next-state: phase sequencing, bit sampling and end-of-transfer update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + PHASE_CNT_W'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    grant_d = grant_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    data_d  = data_q;
    chan_d  = chan_q;
    valid_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (|arb_grant) begin
          grant_d = arb_grant;
          idx_d   = arb_index;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        bit_d = '0;
        if (cnt_q == SETUP_LAST) begin
          cnt_d   = '0;
          state_d = ST_LOW;
        end
      end
      ST_LOW: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d   = '0;
          state_d = ST_HIGH;
          shift_d = {shift_q[bitcount-2:0], sdi};
          bit_d   = bit_q + BIT_W'(1);
        end
      end
      ST_HIGH: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d   = '0;
          state_d = (bit_q == BIT_LAST) ? ST_HOLD : ST_LOW;
        end
      end
      ST_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          cnt_d   = '0;
          grant_d = '0;
          data_d  = shift_q;
          chan_d  = idx_q;
          valid_d = 1'b1;
          ptr_d   = (idx_q == IDX_MAX) ? '0 : idx_q + IDX_W'(1);
          state_d = (gap_cycles > 0) ? ST_GAP : ST_IDLE;
        end
      end
      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // sclk is low exactly while in LOW; registered so the pin is glitch-free.
    sclk_low_d = (state_d == ST_LOW);
  end

  assign grant   = grant_q;
  assign ss      = (ss_polarity == SS_ACTIVE_HIGH) ? grant_q : ~grant_q;
  assign sclk    = (sclk_polarity == SCLK_IDLE_HIGH) ? ~sclk_low_q : sclk_low_q;
  assign data    = data_q;
  assign channel = chan_q;
  assign valid   = valid_q;
  assign busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_spi_poll_scheduler.sv
// Bench for spi_poll_scheduler: two instances (default-like with a fast
// sclk, and an inverted-polarity 8-bit one), slave models that shift words
// out MSB first, and scoreboards fed at request time, drained on valid.
module tb_spi_poll_scheduler;

  typedef struct packed {
    logic [1:0]  ch;
    logic [15:0] d;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  request0, grant0, ss0;
  logic        sclk0, sdi0, valid0, busy0;
  logic [15:0] data0;
  logic [1:0]  channel0;
  logic [3:0]  request1, grant1, ss1;
  logic        sclk1, sdi1, valid1, busy1;
  logic [7:0]  data1;
  logic [1:0]  channel1;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   rise0    = 0;
  int   ns1      = 0;
  int   samp1 [16];
  exp_t q0 [$];
  exp_t q1 [$];
  logic [15:0] wordtab0 [4];
  logic [7:0]  wordtab1 [4];

  always #5 clock = ~clock;

  spi_poll_scheduler #(
    .channels(4), .bitcount(16), .clock_divider(1), .setup_cycles(2),
    .hold_cycles(2), .gap_cycles(2), .ss_polarity(0), .sclk_polarity(1)
  ) dut0 (
    .clock(clock), .reset(reset), .request(request0), .grant(grant0),
    .ss(ss0), .sclk(sclk0), .sdi(sdi0), .data(data0), .channel(channel0),
    .valid(valid0), .busy(busy0)
  );

  spi_poll_scheduler #(
    .channels(4), .bitcount(8), .clock_divider(3), .setup_cycles(2),
    .hold_cycles(2), .gap_cycles(2), .ss_polarity(1), .sclk_polarity(0)
  ) dut1 (
    .clock(clock), .reset(reset), .request(request1), .grant(grant1),
    .ss(ss1), .sclk(sclk1), .sdi(sdi1), .data(data1), .channel(channel1),
    .valid(valid1), .busy(busy1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out", name);
  endtask

  // Wait for any ss0 to go active; idle counts inactive samples (starting at start).
  task automatic wait_active0(input int start, output int idle, output int ch);
    idle = start;
    ch   = -1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clock);
      if (ss0 != 4'hF) begin
        for (int k = 0; k < 4; k++) if (ss0[k] == 1'b0) ch = k;
        return;
      end
      idle++;
    end
    timeout("wait_active0");
  endtask

  // Count samples with ss0 active (the current one included) until it drops.
  task automatic wait_inactive0(output int len);
    len = 1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clock);
      if (ss0 == 4'hF) return;
      len++;
    end
    timeout("wait_inactive0");
  endtask

  task automatic wait_idle0();
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (busy0 == 1'b0) return;
    end
    timeout("wait_idle0");
  endtask

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  initial forever begin
    @(posedge sclk0);
    rise0++;
  end

  // Sampling edges of dut1 are output falling edges (sclk idles low).
  initial forever begin
    @(negedge sclk1);
    if (ss1 != 4'b0000) begin
      if (ns1 < 16) samp1[ns1] = cyc;
      ns1++;
    end
  end

  // Slave model for dut0: load on grant, shift out on sclk falling edges.
  initial begin : slave0
    int bp;
    logic [15:0] w;
    bp   = 15;
    w    = '0;
    sdi0 = 1'b0;
    forever begin
      @(posedge busy0 or negedge sclk0);
      if (sclk0 === 1'b1) begin
        #1;
        w = '0;
        for (int k = 0; k < 4; k++) if (grant0[k]) w = wordtab0[k];
        bp = 15;
      end else begin
        sdi0 = w[bp];
        if (bp > 0) bp--;
      end
    end
  end

  // Slave model for dut1: same idea with inverted sclk pin.
  initial begin : slave1
    int bp;
    logic [7:0] w;
    bp   = 7;
    w    = '0;
    sdi1 = 1'b0;
    forever begin
      @(posedge busy1 or posedge sclk1);
      if (sclk1 === 1'b0) begin
        #1;
        w = '0;
        for (int k = 0; k < 4; k++) if (grant1[k]) w = wordtab1[k];
        bp = 7;
      end else begin
        sdi1 = w[bp];
        if (bp > 0) bp--;
      end
    end
  end

  initial begin : mon0
    exp_t e;
    forever begin
      @(negedge clock);
      if (valid0 === 1'b1) begin
        if (q0.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL dut0_valid: unexpected valid ch=%0d data=%h, none expected", channel0, data0);
        end else begin
          e = q0.pop_front();
          check("dut0_channel", 32'(channel0), 32'(e.ch));
          check("dut0_data", 32'(data0), 32'(e.d));
        end
      end
    end
  end

  initial begin : mon1
    exp_t e;
    forever begin
      @(negedge clock);
      if (valid1 === 1'b1) begin
        if (q1.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL dut1_valid: unexpected valid ch=%0d data=%h, none expected", channel1, data1);
        end else begin
          e = q1.pop_front();
          check("dut1_channel", 32'(channel1), 32'(e.ch));
          check("dut1_data", 32'(data1), 32'(e.d));
        end
      end
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int idle, ch, len, r_base;
    wordtab0 = '{16'h8001, 16'hA5C3, 16'h3C5A, 16'hFFFE};
    wordtab1 = '{8'h11, 8'h22, 8'h81, 8'h44};
    request0 = '0;
    request1 = '0;
    reset    = 1'b1;
    repeat (3) @(negedge clock);
    check("rst_ss0", 32'(ss0), 32'hF);
    check("rst_sclk0", 32'(sclk0), 32'd1);
    check("rst_grant0", 32'(grant0), 32'd0);
    check("rst_data0", 32'(data0), 32'd0);
    check("rst_channel0", 32'(channel0), 32'd0);
    check("rst_valid0", 32'(valid0), 32'd0);
    check("rst_busy0", 32'(busy0), 32'd0);
    check("rst_ss1", 32'(ss1), 32'd0);
    check("rst_sclk1", 32'(sclk1), 32'd0);
    reset = 1'b0;

    // Single transfer on channel 1.
    q0.push_back('{ch: 2'd1, d: 16'hA5C3});
    r_base   = rise0;
    request0 = 4'b0010;
    wait_active0(0, idle, ch);
    request0 = '0;
    check("t1_grant_ch", ch, 1);
    check("t1_grant_onehot", 32'(grant0), 32'h2);
    wait_inactive0(len);
    check("t1_ss_len", len, 36);
    check("t1_sclk_rises", rise0 - r_base, 16);
    check("t1_grant_clear", 32'(grant0), 32'd0);
    wait_idle0();

    // All channels requesting from a fresh pointer.
    @(negedge clock) reset = 1'b1;
    @(negedge clock) reset = 1'b0;
    for (int k = 0; k < 5; k++) q0.push_back('{ch: 2'(k % 4), d: wordtab0[k % 4]});
    request0 = 4'hF;
    wait_active0(0, idle, ch);
    check("t2_first", ch, 0);
    for (int k = 1; k < 5; k++) begin
      wait_inactive0(len);
      check("t2_ss_len", len, 36);
      wait_active0(1, idle, ch);
      if (k == 4) request0 = '0;
      check("t2_gap", idle, 3);
      check("t2_order", ch, k % 4);
    end
    wait_inactive0(len);
    check("t2_ss_len_last", len, 36);
    wait_idle0();

    // Serve channel 3, then a lone held request on 2 wraps past the pointer.
    q0.push_back('{ch: 2'd3, d: wordtab0[3]});
    request0 = 4'b1000;
    wait_active0(0, idle, ch);
    request0 = '0;
    check("t3_ch3", ch, 3);
    wait_inactive0(len);
    wait_idle0();
    q0.push_back('{ch: 2'd2, d: wordtab0[2]});
    q0.push_back('{ch: 2'd2, d: wordtab0[2]});
    request0 = 4'b0100;
    wait_active0(0, idle, ch);
    check("t3_wrap_ch2", ch, 2);
    wait_inactive0(len);
    wait_active0(1, idle, ch);
    request0 = '0;
    check("t3_again_ch2", ch, 2);
    check("t3_gap", idle, 3);
    wait_inactive0(len);
    wait_idle0();

    // Abort mid-transfer with asynchronous reset.
    request0 = 4'b0001;
    wait_active0(0, idle, ch);
    request0 = '0;
    check("t4_ch0", ch, 0);
    r_base = rise0;
    for (int i = 0; i < 200 && (rise0 - r_base) < 6; i++) @(negedge clock);
    check("t4_reached_bit", rise0 - r_base, 6);
    check("t4_data_held", 32'(data0), 32'(wordtab0[2]));
    @(posedge clock);
    #3 reset = 1'b1;
    #1;
    check("t4_ss_async", 32'(ss0), 32'hF);
    check("t4_sclk_async", 32'(sclk0), 32'd1);
    check("t4_grant_async", 32'(grant0), 32'd0);
    check("t4_busy_async", 32'(busy0), 32'd0);
    check("t4_valid_async", 32'(valid0), 32'd0);
    check("t4_data_cleared", 32'(data0), 32'd0);
    @(negedge clock) reset = 1'b0;
    q0.push_back('{ch: 2'd1, d: wordtab0[1]});
    request0 = 4'b1010;
    wait_active0(0, idle, ch);
    request0 = '0;
    check("t4_ptr_restart", ch, 1);
    wait_inactive0(len);
    check("t4_ss_len", len, 36);
    wait_idle0();

    // A one-cycle request while busy is never served.
    q0.push_back('{ch: 2'd0, d: wordtab0[0]});
    request0 = 4'b0001;
    wait_active0(0, idle, ch);
    request0 = '0;
    check("t6_ch0", ch, 0);
    repeat (5) @(negedge clock);
    request0 = 4'b1000;
    @(negedge clock) request0 = '0;
    wait_inactive0(len);
    wait_idle0();
    repeat (20) @(negedge clock);
    check("t6_no_grant_busy", 32'(busy0), 32'd0);
    check("t6_no_grant_ss", 32'(ss0), 32'hF);

    // Inverted polarities, 8 bits, divider 3.
    q1.push_back('{ch: 2'd2, d: 16'h0081});
    check("t5_sclk_idle", 32'(sclk1), 32'd0);
    request1 = 4'b0100;
    len = 0;
    for (int i = 0; i < 100 && ss1 == 4'b0000; i++) @(negedge clock);
    request1 = '0;
    check("t5_ss_active_high", 32'(ss1), 32'h4);
    for (int i = 0; i < 200 && ss1 != 4'b0000; i++) begin
      len++;
      @(negedge clock);
    end
    check("t5_ss_len", len, 52);
    check("t5_samples", ns1, 8);
    for (int k = 1; k < 8; k++) check("t5_spacing", samp1[k] - samp1[k-1], 6);
    check("t5_sclk_idle_after", 32'(sclk1), 32'd0);

    repeat (10) @(negedge clock);
    check("q0_drained", q0.size(), 0);
    check("q1_drained", q1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_poll_scheduler.md
Name: spi_poll_scheduler

Overview:
SPI bus master that shares one sclk/sdi bus among several slave devices, each with its own slave-select line. Requesters raise a per-channel request. The block grants one channel at a time using round-robin arbitration, then generates ss and sclk (CPOL=1, CPHA=1, MSB first) and shifts in bitcount bits. It presents the received word with its channel index and a one-cycle valid pulse. It is the sequencing front end for ADC/sensor read-out paths built from the existing SPI receive logic.

Parameters:
channels, 4, number of slaves/requesters (>=1)
bitcount, 16, bits per transfer (>=2)
clock_divider, 4, system clock cycles per sclk half-period (>=1)
setup_cycles, 2, cycles from ss assertion to first sclk falling edge (>=1)
hold_cycles, 2, cycles from last sclk rising edge plus its high half to ss de-assertion (>=1)
gap_cycles, 2, minimum cycles with all ss inactive between transfers (>=0)
ss_polarity, 0, 1 = active-high ss, 0 = active-low ss
sclk_polarity, 1, idle level of the sclk output (1 = idle high)

Ports:
clock  input  1  system clock; all logic on its rising edge
reset  input  1  asynchronous, active-high reset
request  input  channels  level request per channel
grant  output  channels  one-hot; the channel currently being transferred
ss  output  channels  per-slave select, polarity per ss_polarity
sclk  output  1  serial clock, idles at sclk_polarity
sdi  input  1  shared serial data input
data  output  bitcount  last received word; stable between valid pulses
channel  output  max(1,$clog2(channels))  index of the channel that produced data
valid  output  1  one-cycle pulse: data/channel updated
busy  output  1  high in every state except IDLE

Behaviour:
- Reset (async, immediate): state IDLE; ss all inactive; sclk = idle level; grant = 0; data = 0; channel = 0; valid = 0; busy = 0; round-robin pointer = 0. Assertion mid-transfer aborts the transfer, with no valid pulse and no partial data.
- Internally sclk is modelled active-low: falling edge = slave shifts out, rising edge = master samples. Output is inverted when sclk_polarity = 0.
- States: IDLE -> SETUP -> LOW -> HIGH -> (LOW for the next bit | HOLD after bit bitcount) -> GAP -> IDLE. GAP is skipped when gap_cycles = 0.
- IDLE: each cycle, if any request bit is set, pick the first set bit at or after the pointer, wrapping. On that edge: register grant, assert the matching ss, set busy, enter SETUP. A request dropped before the grant is lost. request is ignored outside IDLE.
- SETUP: setup_cycles cycles with sclk idle.
- LOW: sclk low for clock_divider cycles.
- HIGH: on the edge entering HIGH, sclk goes high and sdi is sampled into the shift register. The shift is MSB first: new bit enters at bit 0 and the register shifts left. HIGH lasts clock_divider cycles.
- Bit counter: width $clog2(bitcount)+1, cleared in SETUP, incremented on each sample. After the HIGH phase of sample bitcount, enter HOLD.
- HOLD: hold_cycles cycles with sclk idle and ss still asserted.
- Exit from HOLD, all on the same edge:
  - ss and grant de-assert.
  - data <= shift register, channel <= granted index.
  - valid = 1 for exactly one cycle.
  - pointer <= granted index + 1, mod channels.
- GAP: gap_cycles cycles with all ss inactive and busy still high. Then IDLE, where a new grant is possible on the next edge.
- ss assertion length is exactly setup_cycles + 2*clock_divider*bitcount + hold_cycles cycles.
- Back-to-back latency, grant edge to next grant edge, is that length + gap_cycles + 1.
- At most one ss is ever active. grant is one-hot or zero. sclk never toggles while all ss are inactive.
- channels = 1: the pointer stays 0 and the channel output is a constant 0.

Decomposition:
- Shared include spi/spi_defs.vh, guarded with `ifndef: state encodings (IDLE, SETUP, LOW, HIGH, HOLD, GAP) and the polarity constants, reused by future SPI masters.
- Sub-module spi_round_robin_arbiter (parameter channels; inputs request, pointer, enable; outputs one-hot grant and index). It is purely combinational; the pointer register stays in the scheduler.

Test Plan:
1. Defaults with clock_divider=1, request=4'b0010, slave model drives 16'hA5C3 MSB first on sclk falling edges -> ss[1] low for 2+32+2=36 cycles, 16 sclk rising edges, valid pulse with data=16'hA5C3, channel=1, grant back to 0.
2. request=4'b1111 held -> grants in order 0,1,2,3,0. Each pair of transfers is separated by exactly 2 gap cycles plus 1 IDLE cycle with all ss high.
3. Single held request=4'b0100 after channel 3 served last -> pointer wraps to 0, channel 2 is still granted, no idle starvation.
4. reset asserted during bit 7 of a transfer -> ss all high and sclk high immediately (asynchronously), no valid pulse, data holds its previous value before reset is cleared to 0. After release, a new request starts cleanly from pointer 0.
5. ss_polarity=1, sclk_polarity=0, bitcount=8, clock_divider=3 -> ss active-high, sclk idles low, 8 samples spaced 6 cycles apart, word 8'h81 received correctly.
6. request pulsed for one cycle while busy, then dropped -> never granted. valid pulses only for the transfer already in progress.
